mpd_pad_cfg_seq: RTL and testbench
==================================

// Module: mpd_pad_cfg_seq
// PURPOSE
//  Parametrised pad-configuration sequencer for the openframe pad ring.
//  Holds every pad at its default config until the fabric has written a
//  magic word that stays stable for STABLE_CYCLES. It then hands
//  fabric-configurable pads over to fabric config one group per cycle, so
//  outputs never switch all at once, and asserts done.
//  On loss of the magic word it reverts to safe defaults at once.
//  Also drives the heartbeat LED and a stretched config-receive LED.
//  Sits between the eFPGA config latches and the per-pad mpd_io_ctrl instances.
// PARAMETERS
//  N_PADS         44          number of pads handled
//  CFG_W          12          config bits per pad
//  GROUP_SIZE     4           pads handed over per cycle; N_GROUPS=ceil(N_PADS/GROUP_SIZE)
//  MAGIC_W        48          magic word width
//  MAGIC          48'hFEEDBADCA77E  value that arms the sequence
//  STABLE_CYCLES  16          consecutive matching cycles required (>=1)
//  HB_DIV         2**22       heartbeat toggle interval in cycles (>=1)
//  STRETCH        2**16       minimum rx LED on-time in cycles (>=1)
//  DEFAULTS       {N_PADS{13'h04c1}}  13 bits per pad; bit12=fabric-configurable, [11:0]=default cfg
// PORTS
//  CLK            in   1            fabric clock
//  por            in   1            asynchronous active-high reset
//  magic_word     in   MAGIC_W      fabric config-latch bits compared with MAGIC
//  done_override  in   1            force hand-over, skipping the stability count
//  fabric_config  in   N_PADS*CFG_W fabric-supplied per-pad config
//  rx_activity    in   1            config receiver activity (level or pulse)
//  pad_cfg        out  N_PADS*CFG_W effective per-pad config (registered)
//  pad_fab        out  N_PADS       1 = pad currently under fabric control
//  done           out  1            hand-over complete
//  busy           out  1            ARM or SWITCH in progress
//  heart_led      out  1            free-running heartbeat
//  rx_led         out  1            stretched rx_activity
// BEHAVIOUR
//  Reset (por high, async): state IDLE; pad_cfg[i]=DEFAULTS[i][11:0]; pad_fab=0;
//   done=0; busy=0; heart_led=0; rx_led=0; all counters 0. Applies mid-sequence too.
//  match = (magic_word==MAGIC), sampled each CLK edge.
//  FSM:
//   IDLE  : match        -> ARM, stable_cnt=1; if STABLE_CYCLES==1 -> SWITCH directly.
//           done_override -> SWITCH, grp=0 (takes priority over match).
//   ARM   : match & stable_cnt==STABLE_CYCLES-1 -> SWITCH, grp=0.
//           match otherwise -> stable_cnt++.
//           !match & !override -> IDLE, stable_cnt=0.  override -> SWITCH.
//   SWITCH: each edge sets pad_fab for group grp.
//           Only pads with DEFAULTS[i][12]=1 are set; others stay 0.
//           grp==N_GROUPS-1 -> DONE; else grp++. Last group may be partial.
//   DONE  : done=1; stays while (match | done_override).
//  Revert: in SWITCH or DONE with !match & !done_override -> IDLE.
//   Clear all pad_fab on the same edge; pad_cfg shows defaults from that edge.
//  pad_cfg[i] updates on the same edge as pad_fab[i]:
//   pad_fab[i] ? fabric_config[i] : DEFAULTS[i][11:0].
//   fabric_config changes under DONE propagate in 1 cycle.
//  busy=1 in ARM/SWITCH. done and busy are registered state decodes.
//  Latency (STABLE_CYCLES=S): first matching sample at edge 1 -> SWITCH at edge S.
//   Group g is applied at edge S+1+g. done=1 after edge S+N_GROUPS.
//  heart_led: counter 0..HB_DIV-1; toggles on wrap. Runs in every state.
//  rx_led: rx_activity high loads STRETCH-1 and sets rx_led=1.
//   The counter decrements otherwise; rx_led clears when it reaches 0 with no activity.
//   Retrigger restarts the full STRETCH.
//  Widths: counters sized by $clog2(param+1). No wrap beyond terminal counts.
// STRUCTURE
//  mpd_pkg: state enum (IDLE/ARM/SWITCH/DONE), cfg-bit position localparams
//   (FAB_EN=12, OUT_VAL=11 ... DM=2:0), and the standard 13-bit default
//   constants (VEC_OUT=13'h02c6, VEC_IN=13'h04c1, BIDIR=13'h0006).
//  One sub-module: mpd_pulse_stretch (parameter STRETCH). Used for rx_led
//   and reusable for other status LEDs.
//  FSM, group counter, pad mux and heartbeat stay inline.
// TESTING  (N_PADS=8, GROUP_SIZE=2, MAGIC_W=16, MAGIC=16'hCAFE, STABLE_CYCLES=4,
//           HB_DIV=5, STRETCH=3, DEFAULTS: pads 0-5 13'h14c1, pads 6-7 13'h04c1)
//  1 Reset: pad_cfg=={8{12'h4c1}}, pad_fab=0, done=0, heart_led=0, rx_led=0.
//  2 Hold magic=CAFE from edge 1: busy at edge 1; pad_fab 8'h03 @5, 8'h0F @6,
//    8'h3F @7 and @8 (pads 6-7 never set); done=1 after edge 8.
//  3 Magic=CAFE for 3 edges then BEEF: back to IDLE, pad_fab=0, done=0.
//    Re-applying CAFE restarts the full 4-cycle count.
//  4 In DONE, magic->0000 for 1 cycle: that edge gives pad_fab=0 and default pad_cfg.
//    The same stimulus with done_override=1 holds DONE throughout.
//  5 done_override pulse in IDLE with no magic: SWITCH next edge.
//    Groups go out on the following 4 edges, then the FSM reverts on the first edge
//    after override drops.
//  6 heart_led toggles every 5 edges. rx pulse at edge 10 gives rx_led high for
//    edges 10-12; a retrigger at edge 12 extends it through edge 14.
//    por asserted mid-SWITCH zeroes outputs asynchronously, before any clock edge.

Source files
------------

// File: rtl/mpd_pkg.sv
// Shared types and constants for the openframe pad-configuration sequencer.
// Default vectors are 13 bits: fabric-enable flag on top of a 12-bit pad config.
package mpd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SWITCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_W   = 13;
    localparam int FAB_EN  = 12;
    localparam int OUT_VAL = 11;
    localparam int DM_MSB  = 2;
    localparam int DM_LSB  = 0;

    localparam logic [DEF_W-1:0] VEC_OUT = 13'h02c6;
    localparam logic [DEF_W-1:0] VEC_IN  = 13'h04c1;
    localparam logic [DEF_W-1:0] BIDIR   = 13'h0006;

    function automatic int n_groups(input int n_pads, input int group_size);
        return (n_pads + group_size - 1) / group_size;
    endfunction

endpackage

// File: rtl/mpd_pad_cfg_seq_if.sv
// Fabric-side bundle of the pad-configuration sequencer: magic word and config in,
// effective pad config, status and LEDs out.
interface mpd_pad_cfg_seq_if #(
    parameter int N_PADS  = 44,
    parameter int CFG_W   = 12,
    parameter int MAGIC_W = 48
);
    logic [MAGIC_W-1:0]      magic_word;
    logic                    done_override;
    logic [N_PADS*CFG_W-1:0] fabric_config;
    logic                    rx_activity;
    logic [N_PADS*CFG_W-1:0] pad_cfg;
    logic [N_PADS-1:0]       pad_fab;
    logic                    done;
    logic                    busy;
    logic                    heart_led;
    logic                    rx_led;

    modport master (
        output magic_word, done_override, fabric_config, rx_activity,
        input  pad_cfg, pad_fab, done, busy, heart_led, rx_led
    );

    modport slave (
        input  magic_word, done_override, fabric_config, rx_activity,
        output pad_cfg, pad_fab, done, busy, heart_led, rx_led
    );
endinterface

// File: rtl/mpd_pulse_stretch.sv
// Stretches a trigger level or pulse so the LED stays lit for at least STRETCH cycles;
// a retrigger restarts the full on-time.
module mpd_pulse_stretch #(
    parameter int STRETCH = 2**16
) (
    input  logic CLK,
    input  logic por,
    input  logic trig,
    output logic led
);
    localparam int W = $clog2(STRETCH + 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge por) begin
        if (por) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (trig) begin
            cnt <= W'(STRETCH - 1);
            led <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            led <= 1'b0;
        end
    end
endmodule

// File: rtl/mpd_pad_cfg_seq.sv
// Pad-configuration sequencer: holds pads at defaults until a stable magic word,
// then hands fabric-configurable pads to fabric config one group per cycle.
module mpd_pad_cfg_seq
    import mpd_pkg::*;
#(
    parameter int                          N_PADS        = 44,
    parameter int                          CFG_W         = 12,
    parameter int                          GROUP_SIZE    = 4,
    parameter int                          MAGIC_W       = 48,
    parameter logic [MAGIC_W-1:0]          MAGIC         = 48'hFEEDBADCA77E,
    parameter int                          STABLE_CYCLES = 16,
    parameter int                          HB_DIV        = 2**22,
    parameter int                          STRETCH       = 2**16,
    parameter logic [N_PADS*DEF_W-1:0]     DEFAULTS      = {N_PADS{VEC_IN}}
) (
    input  logic           CLK,
    input  logic           por,
    mpd_pad_cfg_seq_if.slave bus
);
    localparam int N_GROUPS = n_groups(N_PADS, GROUP_SIZE);
    localparam int SC_W     = $clog2(STABLE_CYCLES + 1);
    localparam int GRP_W    = $clog2(N_GROUPS + 1);
    localparam int HB_W     = $clog2(HB_DIV + 1);

    function automatic logic [N_PADS*CFG_W-1:0] default_cfg();
        logic [N_PADS*CFG_W-1:0] r;
        for (int i = 0; i < N_PADS; i++) r[i*CFG_W +: CFG_W] = DEFAULTS[i*DEF_W +: CFG_W];
        return r;
    endfunction

    localparam logic [N_PADS*CFG_W-1:0] DEF_CFG = default_cfg();

    state_t                  state_q, state_d;
    logic [SC_W-1:0]         stable_q, stable_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [N_PADS-1:0]       fab_q, fab_d;
    logic [N_PADS*CFG_W-1:0] cfg_q, cfg_d;
    logic                    done_q, busy_q;
    logic [HB_W-1:0]         hb_cnt;
    logic                    heart_q;
    logic                    match, ovr;

    assign match = (bus.magic_word == MAGIC);
    assign ovr   = bus.done_override;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        grp_d    = grp_q;
        fab_d    = fab_q;
        unique case (state_q)
            IDLE: begin
                if (ovr) begin
                    state_d = SWITCH;
                    grp_d   = '0;
                end else if (match) begin
                    stable_d = SC_W'(1);
                    grp_d    = '0;
                    state_d  = (STABLE_CYCLES == 1) ? SWITCH : ARM;
                end
            end
            ARM: begin
                if (match && stable_q == SC_W'(STABLE_CYCLES - 1)) begin
                    state_d  = SWITCH;
                    stable_d = '0;
                    grp_d    = '0;
                end else if (match) begin
                    stable_d = stable_q + 1'b1;
                end else if (ovr) begin
                    state_d  = SWITCH;
                    stable_d = '0;
                    grp_d    = '0;
                end else begin
                    state_d  = IDLE;
                    stable_d = '0;
                end
            end
            SWITCH: begin
                if (!match && !ovr) begin
                    state_d = IDLE;
                    fab_d   = '0;
                    grp_d   = '0;
                end else begin
                    // Only pads flagged fabric-configurable in DEFAULTS are ever handed over.
                    for (int i = 0; i < N_PADS; i++)
                        if ((i / GROUP_SIZE) == int'(grp_q) && DEFAULTS[i*DEF_W + FAB_EN])
                            fab_d[i] = 1'b1;
                    if (grp_q == GRP_W'(N_GROUPS - 1)) begin
                        state_d = DONE;
                        grp_d   = '0;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!match && !ovr) begin
                    state_d = IDLE;
                    fab_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < N_PADS; i++)
            cfg_d[i*CFG_W +: CFG_W] = fab_d[i] ? bus.fabric_config[i*CFG_W +: CFG_W]
                                               : DEF_CFG[i*CFG_W +: CFG_W];
    end

    always_ff @(posedge CLK or posedge por) begin
        if (por) begin
            state_q  <= IDLE;
            stable_q <= '0;
            grp_q    <= '0;
            fab_q    <= '0;
            cfg_q    <= DEF_CFG;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            grp_q    <= grp_d;
            fab_q    <= fab_d;
            cfg_q    <= cfg_d;
            done_q   <= (state_d == DONE);
            busy_q   <= (state_d == ARM) || (state_d == SWITCH);
        end
    end

    always_ff @(posedge CLK or posedge por) begin
        if (por) begin
            hb_cnt  <= '0;
            heart_q <= 1'b0;
        end else if (hb_cnt == HB_W'(HB_DIV - 1)) begin
            hb_cnt  <= '0;
            heart_q <= ~heart_q;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    mpd_pulse_stretch #(.STRETCH(STRETCH)) u_rx_stretch (
        .CLK  (CLK),
        .por  (por),
        .trig (bus.rx_activity),
        .led  (bus.rx_led)
    );

    assign bus.pad_cfg   = cfg_q;
    assign bus.pad_fab   = fab_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.heart_led = heart_q;
endmodule

// File: tb/tb_mpd_pad_cfg_seq.sv
// Self-checking bench for mpd_pad_cfg_seq: vector table, directed corner sequences,
// and randomized traffic against a counting reference model.
module tb_mpd_pad_cfg_seq;
    localparam int NP = 8, CW = 12, GS = 2, MW = 16, S = 4, HB = 5, ST = 3, NG = 4;
    localparam logic [MW-1:0]      MAGIC = 16'hCAFE;
    localparam logic [NP*13-1:0]   DEFS  = {13'h04c1, 13'h04c1, {6{13'h14c1}}};
    localparam logic [NP*CW-1:0]   DEF_CFG = {8{12'h4c1}};

    logic CLK = 1'b0;
    logic por = 1'b1;
    always #5 CLK = ~CLK;

    mpd_pad_cfg_seq_if #(.N_PADS(NP), .CFG_W(CW), .MAGIC_W(MW)) bus ();

    mpd_pad_cfg_seq #(
        .N_PADS(NP), .CFG_W(CW), .GROUP_SIZE(GS), .MAGIC_W(MW), .MAGIC(MAGIC),
        .STABLE_CYCLES(S), .HB_DIV(HB), .STRETCH(ST), .DEFAULTS(DEFS)
    ) dut (
        .CLK (CLK),
        .por (por),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: counts matching samples and groups handed over.
    int              m_edge, m_hold, m_ga, m_last_rx;
    bit              m_hand;
    logic [NP*CW-1:0] m_fc;

    function automatic logic [NP-1:0] m_fab();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = m_hand && DEFS[i*13 + 12] && ((i / GS) < m_ga);
        return r;
    endfunction

    function automatic logic [NP*CW-1:0] exp_cfg(input logic [NP-1:0] fab, input logic [NP*CW-1:0] fc);
        logic [NP*CW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*CW +: CW] = fab[i] ? fc[i*CW +: CW] : 12'h4c1;
        return r;
    endfunction

    task automatic model_reset();
        m_edge = 0; m_hold = 0; m_ga = 0; m_last_rx = -1000; m_hand = 0; m_fc = '0;
    endtask

    task automatic model_edge(input logic [MW-1:0] magic, input logic ovr, input logic rx,
                              input logic [NP*CW-1:0] fc);
        bit match;
        match = (magic == MAGIC);
        m_edge++;
        if (rx) m_last_rx = m_edge;
        m_fc = fc;
        if (m_hand) begin
            if (!match && !ovr) begin m_hand = 0; m_ga = 0; m_hold = 0; end
            else if (m_ga < NG) m_ga++;
        end else if (m_hold == 0) begin
            if (ovr) m_hand = 1;
            else if (match) begin m_hold = 1; if (m_hold == S) m_hand = 1; end
        end else if (match) begin
            m_hold++;
            if (m_hold == S) m_hand = 1;
        end else if (ovr) begin
            m_hand = 1;
        end else begin
            m_hold = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [NP-1:0] f;
        f = m_fab();
        check({tag, "_fab"},   128'(bus.pad_fab), 128'(f));
        check({tag, "_cfg"},   128'(bus.pad_cfg), 128'(exp_cfg(f, m_fc)));
        check({tag, "_done"},  128'(bus.done),  128'(m_hand && m_ga == NG));
        check({tag, "_busy"},  128'(bus.busy),  128'(m_hand ? (m_ga < NG) : (m_hold > 0)));
        check({tag, "_heart"}, 128'(bus.heart_led), 128'(((m_edge / HB) % 2) == 1));
        check({tag, "_rx"},    128'(bus.rx_led), 128'((m_edge - m_last_rx) < ST));
    endtask

    // Drive inputs, take one edge, then sample 1 time unit after it.
    task automatic drive(input logic [MW-1:0] magic, input logic ovr, input logic rx,
                         input logic [NP*CW-1:0] fc);
        bus.magic_word    = magic;
        bus.done_override = ovr;
        bus.rx_activity   = rx;
        bus.fabric_config = fc;
        @(posedge CLK);
        model_edge(magic, ovr, rx, fc);
        #1;
    endtask

    task automatic do_reset();
        por = 1'b1;
        bus.magic_word = '0; bus.done_override = 1'b0; bus.rx_activity = 1'b0; bus.fabric_config = '0;
        @(posedge CLK);
        #1;
        por = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [MW-1:0]    magic;
        logic             ovr;
        logic [NP*CW-1:0] fc;
        logic [NP-1:0]    fab;
        logic             done;
        logic             busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NP*CW-1:0] fa, fb;
        logic [15:0]      hb_tab, rx_tab;
        logic [NP-1:0]    ov_fab[6];
        fa = {8{12'hA5C}};
        fb = {4{24'h3C7_912}};
        hb_tab = 16'h83E0;
        rx_tab = 16'h7C00;

        tbl[0] = '{MAGIC, 1'b0, fa, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{MAGIC, 1'b0, fa, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{MAGIC, 1'b0, fa, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{MAGIC, 1'b0, fa, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{MAGIC, 1'b0, fa, 8'h03, 1'b0, 1'b1};
        tbl[5] = '{MAGIC, 1'b0, fa, 8'h0F, 1'b0, 1'b1};
        tbl[6] = '{MAGIC, 1'b0, fa, 8'h3F, 1'b0, 1'b1};
        tbl[7] = '{MAGIC, 1'b0, fa, 8'h3F, 1'b1, 1'b0};
        tbl[8] = '{16'h0000, 1'b1, fb, 8'h3F, 1'b1, 1'b0};
        tbl[9] = '{16'h0000, 1'b0, fb, 8'h00, 1'b0, 1'b0};

        // Reset values
        do_reset();
        check("rst_cfg",   128'(bus.pad_cfg), 128'(DEF_CFG));
        check("rst_fab",   128'(bus.pad_fab), 128'(8'h00));
        check("rst_done",  128'(bus.done), 128'(1'b0));
        check("rst_busy",  128'(bus.busy), 128'(1'b0));
        check("rst_heart", 128'(bus.heart_led), 128'(1'b0));
        check("rst_rx",    128'(bus.rx_led), 128'(1'b0));

        // Full hand-over, DONE hold under override, revert on magic loss
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].magic, tbl[k].ovr, 1'b0, tbl[k].fc);
            check($sformatf("tbl%0d_fab", k),  128'(bus.pad_fab), 128'(tbl[k].fab));
            check($sformatf("tbl%0d_cfg", k),  128'(bus.pad_cfg), 128'(exp_cfg(tbl[k].fab, tbl[k].fc)));
            check($sformatf("tbl%0d_done", k), 128'(bus.done), 128'(tbl[k].done));
            check($sformatf("tbl%0d_busy", k), 128'(bus.busy), 128'(tbl[k].busy));
        end

        // Magic lost after 3 edges: back to IDLE, then a full 4-edge count again
        do_reset();
        for (int k = 0; k < 3; k++) drive(MAGIC, 1'b0, 1'b0, '0);
        drive(16'hBEEF, 1'b0, 1'b0, '0);
        check("abort_busy", 128'(bus.busy), 128'(1'b0));
        check("abort_fab",  128'(bus.pad_fab), 128'(8'h00));
        check("abort_done", 128'(bus.done), 128'(1'b0));
        for (int k = 0; k < 4; k++) drive(MAGIC, 1'b0, 1'b0, '0);
        check("restart_fab4", 128'(bus.pad_fab), 128'(8'h00));
        drive(MAGIC, 1'b0, 1'b0, '0);
        check("restart_fab5", 128'(bus.pad_fab), 128'(8'h03));
        check("restart_cfg5", 128'(bus.pad_cfg), 128'({{6{12'h4c1}}, 24'h0}));

        // done_override without magic: SWITCH next edge, four groups, revert when dropped
        do_reset();
        ov_fab = '{8'h00, 8'h03, 8'h0F, 8'h3F, 8'h3F, 8'h00};
        for (int k = 0; k < 6; k++) begin
            drive(16'h0000, (k < 5), 1'b0, '0);
            check($sformatf("ovr%0d_fab", k),  128'(bus.pad_fab), 128'(ov_fab[k]));
            check($sformatf("ovr%0d_done", k), 128'(bus.done), 128'(k == 4));
            check($sformatf("ovr%0d_busy", k), 128'(bus.busy), 128'(k < 4));
        end

        // Heartbeat and rx stretch with a retrigger
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            drive(16'h0000, 1'b0, (e == 10 || e == 12), '0);
            check($sformatf("hb_e%0d", e), 128'(bus.heart_led), 128'(hb_tab[e]));
            check($sformatf("rx_e%0d", e), 128'(bus.rx_led), 128'(rx_tab[e]));
        end

        // Asynchronous por in the middle of SWITCH
        do_reset();
        for (int k = 0; k < 5; k++) drive(MAGIC, 1'b0, (k == 4), {8{12'h123}});
        check("pre_por_fab", 128'(bus.pad_fab), 128'(8'h03));
        #3;
        por = 1'b1;
        #1;
        check("por_fab",   128'(bus.pad_fab), 128'(8'h00));
        check("por_cfg",   128'(bus.pad_cfg), 128'(DEF_CFG));
        check("por_busy",  128'(bus.busy), 128'(1'b0));
        check("por_heart", 128'(bus.heart_led), 128'(1'b0));
        check("por_rx",    128'(bus.rx_led), 128'(1'b0));

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic [MW-1:0]    mg;
            logic [NP*CW-1:0] fc;
            mg = ($urandom_range(0, 19) != 0) ? MAGIC : 16'($urandom());
            fc = {$urandom(), $urandom(), $urandom()};
            drive(mg, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), fc);
            check_model($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
